// File: rtl/fixed_latency_stage_ctrl_if.sv
// Handshake and datapath-capture signals of a fixed-latency stage controller.
// master: the surrounding logic (upstream, datapath, downstream).
// slave:  the controller itself.
interface fixed_latency_stage_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BUF_DEPTH  = 9
);
    localparam int unsigned OCC_W = $clog2(BUF_DEPTH + 1);

    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic                  dp_issue;
    logic [DATA_WIDTH-1:0] dp_result;
    logic                  dp_result_valid;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [OCC_W-1:0]      occupancy;
    logic                  idle;

    modport master (
        output flush, in_valid, dp_result, out_ready,
        input  in_ready, dp_issue, dp_result_valid, out_valid, out_data, occupancy, idle
    );

    modport slave (
        input  flush, in_valid, dp_result, out_ready,
        output in_ready, dp_issue, dp_result_valid, out_valid, out_data, occupancy, idle
    );
endinterface

// File: rtl/fixed_latency_stage_ctrl.sv
// Ready/valid controller for a non-stallable fixed-latency datapath.
// Issues are tracked by a valid-tag shift register; results land in a credit
// protected circular FIFO, so a result never arrives while the FIFO is full.
module fixed_latency_stage_ctrl #(
    parameter int unsigned LATENCY    = 7,
    parameter int unsigned II         = 1,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BUF_DEPTH  = 9
) (
    input logic                       clk,
    input logic                       rst,
    fixed_latency_stage_ctrl_if.slave bus
);
    localparam int unsigned OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

    logic [LATENCY-1:0]    tags;
    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [OCC_W-1:0]      buf_cnt;
    logic [OCC_W-1:0]      occ;
    logic                  ii_zero;
    logic                  in_ready;
    logic                  dp_issue;
    logic                  wr_en;
    logic                  out_valid;
    logic                  pop;

    // Circular pointer increment; depth need not be a power of two
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Accept only when spacing has elapsed and a result slot is reserved
    assign in_ready  = ~rst & ~bus.flush & ii_zero & (occ < OCC_W'(BUF_DEPTH));
    assign dp_issue  = bus.in_valid & in_ready;
    assign wr_en     = tags[LATENCY-1] & ~bus.flush;
    assign out_valid = (buf_cnt != '0) & ~bus.flush;
    assign pop       = out_valid & bus.out_ready;

    assign bus.in_ready        = in_ready;
    assign bus.dp_issue        = dp_issue;
    assign bus.dp_result_valid = tags[LATENCY-1];
    assign bus.out_valid       = out_valid;
    assign bus.out_data        = (buf_cnt != '0) ? mem[rd_ptr] : '0;
    assign bus.occupancy       = occ;
    assign bus.idle            = (occ == '0);

    // Minimum issue spacing counter; degenerates to a constant for II == 1
    if (II > 1) begin : g_ii
        localparam int unsigned II_W = $clog2(II);
        logic [II_W-1:0] ii_cnt;

        // Reload on issue, count down to zero otherwise
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ii_cnt <= '0;
            end else if (bus.flush) begin
                ii_cnt <= '0;
            end else if (dp_issue) begin
                ii_cnt <= II_W'(II - 1);
            end else if (ii_cnt != '0) begin
                ii_cnt <= ii_cnt - II_W'(1);
            end
        end

        assign ii_zero = (ii_cnt == '0);
    end else begin : g_no_ii
        assign ii_zero = 1'b1;
    end

    // Valid-tag pipeline mirroring the datapath depth
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tags <= '0;
        end else if (bus.flush) begin
            tags <= '0;
        end else begin
            tags <= (tags << 1) | LATENCY'(dp_issue);
        end
    end

    // Result storage; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= bus.dp_result;
        end
    end

    // FIFO pointers and fill count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            buf_cnt <= '0;
        end else if (bus.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            buf_cnt <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({wr_en, pop})
                2'b10:   buf_cnt <= buf_cnt + OCC_W'(1);
                2'b01:   buf_cnt <= buf_cnt - OCC_W'(1);
                default: buf_cnt <= buf_cnt;
            endcase
        end
    end

    // Credit count: in-flight plus buffered transactions
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ <= '0;
        end else if (bus.flush) begin
            occ <= '0;
        end else begin
            case ({dp_issue, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end
endmodule

// File: tb/tb_fixed_latency_stage_ctrl.sv
// Bench for fixed_latency_stage_ctrl: two configurations driven side by side
// and compared every cycle against a transaction-level model (issue times and
// a result queue), plus scenario-specific checks.
module tb_fixed_latency_stage_ctrl;
    localparam int unsigned DW = 32;
    localparam int LAT_K [2] = '{7, 4};
    localparam int II_K  [2] = '{1, 3};
    localparam int BUF_K [2] = '{9, 4};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          flush_s     [2];
    logic          in_valid_s  [2];
    logic          out_ready_s [2];
    logic [DW-1:0] dp_result_s [2];

    logic          o_ir [2], o_iss [2], o_rv [2], o_ov [2], o_idle [2];
    logic [DW-1:0] o_od [2];
    logic [31:0]   o_occ [2];

    fixed_latency_stage_ctrl_if #(.DATA_WIDTH(DW), .BUF_DEPTH(BUF_K[0])) if_a ();
    fixed_latency_stage_ctrl_if #(.DATA_WIDTH(DW), .BUF_DEPTH(BUF_K[1])) if_b ();

    fixed_latency_stage_ctrl #(
        .LATENCY(LAT_K[0]), .II(II_K[0]), .DATA_WIDTH(DW), .BUF_DEPTH(BUF_K[0])
    ) dut_a (.clk(clk), .rst(rst), .bus(if_a));

    fixed_latency_stage_ctrl #(
        .LATENCY(LAT_K[1]), .II(II_K[1]), .DATA_WIDTH(DW), .BUF_DEPTH(BUF_K[1])
    ) dut_b (.clk(clk), .rst(rst), .bus(if_b));

    assign if_a.flush = flush_s[0];
    assign if_a.in_valid = in_valid_s[0];
    assign if_a.out_ready = out_ready_s[0];
    assign if_a.dp_result = dp_result_s[0];
    assign if_b.flush = flush_s[1];
    assign if_b.in_valid = in_valid_s[1];
    assign if_b.out_ready = out_ready_s[1];
    assign if_b.dp_result = dp_result_s[1];

    assign o_ir[0] = if_a.in_ready;          assign o_ir[1] = if_b.in_ready;
    assign o_iss[0] = if_a.dp_issue;         assign o_iss[1] = if_b.dp_issue;
    assign o_rv[0] = if_a.dp_result_valid;   assign o_rv[1] = if_b.dp_result_valid;
    assign o_ov[0] = if_a.out_valid;         assign o_ov[1] = if_b.out_valid;
    assign o_od[0] = if_a.out_data;          assign o_od[1] = if_b.out_data;
    assign o_idle[0] = if_a.idle;            assign o_idle[1] = if_b.idle;
    assign o_occ[0] = 32'(if_a.occupancy);   assign o_occ[1] = 32'(if_b.occupancy);

    // Model state: issue cycles of transactions still in the datapath, and
    // the results waiting downstream, oldest first.
    int            infl [2][$];
    logic [DW-1:0] fq   [2][$];
    int            last_iss [2];
    int            cyc;
    int            n_checks;
    int            n_pass;

    logic          e_iss [2], e_rv [2], e_ov [2];
    logic          c_ir [2], c_iss [2], c_rv [2], c_ov [2], c_idle [2];
    logic [DW-1:0] c_od [2];
    logic [31:0]   c_occ [2];

    task automatic model_clear(input int k);
        infl[k].delete();
        fq[k].delete();
        last_iss[k] = -1000;
    endtask

    task automatic idle_inputs();
        for (int k = 0; k < 2; k++) begin
            flush_s[k]     = 1'b0;
            in_valid_s[k]  = 1'b0;
            out_ready_s[k] = 1'b1;
            dp_result_s[k] = '0;
        end
    endtask

    // One clock: compare outputs with the model at the falling edge, then
    // advance the model across the rising edge.
    task automatic step();
        logic [DW-1:0] got [7];
        logic [DW-1:0] ex  [7];
        string         nm  [7];
        int            n;
        int            occm;
        nm = '{"in_ready", "dp_issue", "dp_result_valid", "out_valid", "occupancy", "idle", "out_data"};
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) model_clear(k);
            occm  = infl[k].size() + fq[k].size();
            ex[0] = DW'(!rst && !flush_s[k] && (cyc - last_iss[k] >= II_K[k]) && (occm < BUF_K[k]));
            ex[1] = DW'(in_valid_s[k] && ex[0][0]);
            ex[2] = DW'((infl[k].size() > 0) && (infl[k][0] + LAT_K[k] == cyc));
            ex[3] = DW'(!flush_s[k] && (fq[k].size() > 0));
            ex[4] = DW'(occm);
            ex[5] = DW'(occm == 0);
            ex[6] = (fq[k].size() > 0) ? fq[k][0] : '0;
            got[0] = DW'(o_ir[k]);  got[1] = DW'(o_iss[k]); got[2] = DW'(o_rv[k]);
            got[3] = DW'(o_ov[k]);  got[4] = o_occ[k];      got[5] = DW'(o_idle[k]);
            got[6] = o_od[k];
            n = (fq[k].size() > 0) ? 7 : 6;
            for (int j = 0; j < n; j++) begin
                n_checks++;
                if (got[j] !== ex[j])
                    $display("FAIL %s[%0d] cycle %0d: got %0h expected %0h", nm[j], k, cyc, got[j], ex[j]);
                else
                    n_pass++;
            end
            e_iss[k] = ex[1][0];
            e_rv[k]  = ex[2][0];
            e_ov[k]  = ex[3][0];
            c_ir[k] = o_ir[k];  c_iss[k] = o_iss[k]; c_rv[k] = o_rv[k];
            c_ov[k] = o_ov[k];  c_od[k] = o_od[k];   c_occ[k] = o_occ[k];
            c_idle[k] = o_idle[k];
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst || flush_s[k]) begin
                model_clear(k);
            end else begin
                if (e_ov[k] && out_ready_s[k]) void'(fq[k].pop_front());
                if (e_rv[k]) begin
                    void'(infl[k].pop_front());
                    fq[k].push_back(dp_result_s[k]);
                end
                if (e_iss[k]) begin
                    infl[k].push_back(cyc);
                    last_iss[k] = cyc;
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        in_valid_s[0] = 1'b1;
        in_valid_s[1] = 1'b1;
        rst = 1'b1;
        repeat (3) step();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (c_ir[k] !== 1'b0 || c_ov[k] !== 1'b0 || c_occ[k] !== 0 || c_idle[k] !== 1'b1)
                $display("FAIL reset_state[%0d]: got ir=%b ov=%b occ=%0d idle=%b expected 0 0 0 1",
                         k, c_ir[k], c_ov[k], c_occ[k], c_idle[k]);
            else n_pass++;
        end
        rst = 1'b0;
        step();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (c_ir[k] !== 1'b1 || c_iss[k] !== 1'b1)
                $display("FAIL reset_release[%0d]: got ir=%b issue=%b expected 1 1", k, c_ir[k], c_iss[k]);
            else n_pass++;
        end
        idle_inputs();
        repeat (12) step();
    endtask

    task automatic test_single_op();
        int t0, rv_n, rv_cyc, ov_cyc;
        logic [DW-1:0] ov_data;
        idle_inputs();
        repeat (2) step();
        t0 = cyc; rv_n = 0; rv_cyc = -1; ov_cyc = -1; ov_data = '0;
        in_valid_s[0] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            dp_result_s[0] = (cyc == t0 + 7) ? 32'hCAFE : DW'($urandom);
            step();
            in_valid_s[0] = 1'b0;
            if (c_rv[0]) begin rv_n++; rv_cyc = t0 + i; end
            if (c_ov[0] && ov_cyc < 0) begin ov_cyc = t0 + i; ov_data = c_od[0]; end
        end
        n_checks++;
        if (rv_n !== 1 || rv_cyc !== t0 + 7)
            $display("FAIL single_result_valid: got %0d pulses at cycle %0d expected 1 at %0d", rv_n, rv_cyc, t0 + 7);
        else n_pass++;
        n_checks++;
        if (ov_cyc !== t0 + 8)
            $display("FAIL single_out_cycle: got %0d expected %0d", ov_cyc, t0 + 8);
        else n_pass++;
        n_checks++;
        if (ov_data !== 32'hCAFE)
            $display("FAIL single_out_data: got %0h expected cafe", ov_data);
        else n_pass++;
        n_checks++;
        if (c_idle[0] !== 1'b1)
            $display("FAIL single_idle_after: got %b expected 1", c_idle[0]);
        else n_pass++;
    endtask

    task automatic test_streaming();
        int t0, iss_n, pop_idx, first_pop, last_pop;
        idle_inputs();
        step();
        t0 = cyc; iss_n = 0; pop_idx = 0; first_pop = -1; last_pop = -1;
        for (int i = 0; i < 130; i++) begin
            in_valid_s[0]  = (i < 100);
            dp_result_s[0] = DW'(cyc - t0 - 7);
            step();
            if (c_iss[0]) iss_n++;
            if (c_ov[0]) begin
                n_checks++;
                if (c_od[0] !== DW'(pop_idx))
                    $display("FAIL stream_order: got %0d expected %0d", c_od[0], pop_idx);
                else n_pass++;
                if (first_pop < 0) first_pop = i;
                last_pop = i;
                pop_idx++;
            end
        end
        n_checks++;
        if (iss_n !== 100) $display("FAIL stream_issues: got %0d expected 100", iss_n);
        else n_pass++;
        n_checks++;
        if (pop_idx !== 100 || last_pop - first_pop !== 99)
            $display("FAIL stream_outputs: got %0d over %0d cycles expected 100 over 100", pop_idx, last_pop - first_pop + 1);
        else n_pass++;
    endtask

    task automatic test_ii();
        int prev, first, iss_n;
        idle_inputs();
        step();
        prev = -1; first = -1; iss_n = 0;
        in_valid_s[1] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            dp_result_s[1] = DW'($urandom);
            step();
            if (c_iss[1]) begin
                if (prev >= 0) begin
                    n_checks++;
                    if (i - prev !== 3) $display("FAIL ii_spacing: got %0d expected 3", i - prev);
                    else n_pass++;
                end else first = i;
                prev = i;
                iss_n++;
            end
        end
        n_checks++;
        if (iss_n !== 10 || first !== 0)
            $display("FAIL ii_count: got %0d first at %0d expected 10 first at 0", iss_n, first);
        else n_pass++;
        idle_inputs();
        repeat (10) step();
    endtask

    task automatic test_backpressure();
        int iss_n, pops;
        idle_inputs();
        step();
        iss_n = 0; pops = 0;
        out_ready_s[1] = 1'b0;
        in_valid_s[1]  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            dp_result_s[1] = DW'($urandom);
            step();
            if (c_iss[1]) iss_n++;
        end
        in_valid_s[1] = 1'b0;
        n_checks++;
        if (iss_n !== 4 || c_occ[1] !== 4 || c_ir[1] !== 1'b0 || c_ov[1] !== 1'b1)
            $display("FAIL bp_full: got issues=%0d occ=%0d ir=%b ov=%b expected 4 4 0 1", iss_n, c_occ[1], c_ir[1], c_ov[1]);
        else n_pass++;
        out_ready_s[1] = 1'b1;
        step();
        pops++;
        n_checks++;
        if (c_ir[1] !== 1'b0) $display("FAIL bp_same_cycle_credit: got ir=%b expected 0", c_ir[1]);
        else n_pass++;
        out_ready_s[1] = 1'b0;
        step();
        n_checks++;
        if (c_occ[1] !== 3 || c_ir[1] !== 1'b1)
            $display("FAIL bp_credit_return: got occ=%0d ir=%b expected 3 1", c_occ[1], c_ir[1]);
        else n_pass++;
        out_ready_s[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (c_ov[1]) pops++;
        end
        n_checks++;
        if (pops !== 4 || c_idle[1] !== 1'b1)
            $display("FAIL bp_drain: got %0d results idle=%b expected 4 1", pops, c_idle[1]);
        else n_pass++;
    endtask

    task automatic test_flush();
        int stale;
        idle_inputs();
        step();
        out_ready_s[0] = 1'b0;
        in_valid_s[0]  = 1'b1;
        repeat (2) begin dp_result_s[0] = DW'($urandom); step(); end
        in_valid_s[0] = 1'b0;
        repeat (8) begin dp_result_s[0] = DW'($urandom); step(); end
        in_valid_s[0] = 1'b1;
        repeat (3) step();
        in_valid_s[0] = 1'b0;
        step();
        n_checks++;
        if (c_occ[0] !== 5 || c_ov[0] !== 1'b1)
            $display("FAIL flush_setup: got occ=%0d ov=%b expected 5 1", c_occ[0], c_ov[0]);
        else n_pass++;
        flush_s[0] = 1'b1;
        step();
        flush_s[0]     = 1'b0;
        out_ready_s[0] = 1'b1;
        step();
        n_checks++;
        if (c_occ[0] !== 0 || c_ov[0] !== 1'b0 || c_idle[0] !== 1'b1)
            $display("FAIL flush_clear: got occ=%0d ov=%b idle=%b expected 0 0 1", c_occ[0], c_ov[0], c_idle[0]);
        else n_pass++;
        stale = 0;
        repeat (10) begin step(); if (c_rv[0]) stale++; end
        n_checks++;
        if (stale !== 0) $display("FAIL flush_stale_tags: got %0d result pulses expected 0", stale);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        idle_inputs();
        in_valid_s[0] = 1'b1;
        in_valid_s[1] = 1'b1;
        for (int i = 0; i < 15; i++) begin
            for (int k = 0; k < 2; k++) begin
                out_ready_s[k] = ($urandom_range(1, 0) == 1);
                dp_result_s[k] = DW'($urandom);
            end
            step();
        end
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (c_occ[k] === 0) $display("FAIL areset_busy[%0d]: got occ=0 expected nonzero", k);
            else n_pass++;
        end
        #2;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (o_ir[k] !== 1'b0 || o_iss[k] !== 1'b0 || o_rv[k] !== 1'b0 ||
                o_ov[k] !== 1'b0 || o_occ[k] !== 0 || o_idle[k] !== 1'b1)
                $display("FAIL areset_immediate[%0d]: got ir=%b iss=%b rv=%b ov=%b occ=%0d idle=%b expected 0 0 0 0 0 1",
                         k, o_ir[k], o_iss[k], o_rv[k], o_ov[k], o_occ[k], o_idle[k]);
            else n_pass++;
        end
        step();
        rst = 1'b0;
        idle_inputs();
        repeat (3) step();
    endtask

    task automatic test_random();
        int pops [2];
        int p_in, p_out;
        pops = '{0, 0};
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) begin
                p_in  = $urandom_range(100, 20);
                p_out = $urandom_range(100, 10);
            end
            for (int k = 0; k < 2; k++) begin
                in_valid_s[k]  = ($urandom_range(99, 0) < p_in);
                out_ready_s[k] = ($urandom_range(99, 0) < p_out);
                flush_s[k]     = ($urandom_range(63, 0) == 0);
                dp_result_s[k] = DW'($urandom);
            end
            step();
            for (int k = 0; k < 2; k++) if (c_ov[k] && out_ready_s[k]) pops[k]++;
        end
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (pops[k] < 100) $display("FAIL random_traffic[%0d]: got %0d results expected at least 100", k, pops[k]);
            else n_pass++;
        end
        idle_inputs();
        repeat (12) step();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        rst      = 1'b1;
        idle_inputs();
        model_clear(0);
        model_clear(1);
        test_reset();
        test_single_op();
        test_streaming();
        test_ii();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
